game_controller: RTL and testbench



---
 rtl/snake_pkg.sv | 29 ++
 rtl/step_timer.sv | 39 +++
 rtl/game_controller.sv | 172 +++++++++++++++++
 tb/tb_game_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer: state encoding and score width.
`default_nettype none

package snake_pkg;

  localparam int SCORE_W       = 4;
  localparam int WIN_SCORE_DEF = 15;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PLAY    = 3'd1;
  localparam logic [2:0] ST_STEP    = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_OVER    = 3'd4;
  localparam logic [2:0] ST_WIN     = 3'd5;
  localparam logic [2:0] ST_RESTART = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_PLAY    = ST_PLAY,
    S_STEP    = ST_STEP,
    S_CHECK   = ST_CHECK,
    S_OVER    = ST_OVER,
    S_WIN     = ST_WIN,
    S_RESTART = ST_RESTART
  } state_e;

endpackage

`default_nettype wire

// File: rtl/step_timer.sv
// Loadable down-counter that times the gap between snake movement steps.
`default_nettype none

module step_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // Load wins over enable; the count parks at zero instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/game_controller.sv
// Snake game sequencer: owns game state, paces movement steps by score and
// handshakes each step with the collision checker.
`default_nettype none

module game_controller
  import snake_pkg::*;
#(
  parameter int BASE_PERIOD   = 6_500_000,
  parameter int SPEEDUP       = 325_000,
  parameter int MIN_PERIOD    = 1_625_000,
  parameter int WIN_SCORE     = WIN_SCORE_DEF,
  parameter int CHECK_TIMEOUT = 255
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic [SCORE_W-1:0] score,
  input  logic               check_done,
  input  logic               collision,
  output logic               step,
  output logic               check_req,
  output logic               game_rst,
  output logic               playing,
  output logic               game_over,
  output logic               victory,
  output logic               fault,
  output logic [2:0]         state
);

  localparam int CW = $clog2(BASE_PERIOD + 1);
  // Extra headroom so score*SPEEDUP + MIN_PERIOD cannot overflow the compare.
  localparam int PW = CW + SCORE_W + 1;
  localparam int TW = $clog2(CHECK_TIMEOUT + 1);

  localparam logic [TW-1:0]      TO_LAST = TW'(CHECK_TIMEOUT - 1);
  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);

  state_e        state_q, state_d;
  logic          start_q;
  logic [TW-1:0] to_q, to_d;
  logic          step_q, step_d;
  logic          check_req_q, check_req_d;
  logic          game_rst_q, game_rst_d;
  logic          playing_q, playing_d;
  logic          game_over_q, game_over_d;
  logic          victory_q, victory_d;
  logic          fault_q, fault_d;

  logic          start_rise;
  logic          timer_load, timer_en, timer_zero;
  logic [PW-1:0] dec;
  logic [CW-1:0] period, load_val;

  assign start_rise = start & ~start_q;

  always_comb begin
    dec = PW'(score) * PW'(SPEEDUP);
    if ((dec + PW'(MIN_PERIOD)) > PW'(BASE_PERIOD)) begin
      period = CW'(MIN_PERIOD);
    end else begin
      period = CW'(PW'(BASE_PERIOD) - dec);
    end
  end

  assign load_val = period - CW'(1);

  step_timer #(.W(CW)) u_step_timer (
    .clk      (pclk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (load_val),
    .en       (timer_en),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    to_d       = to_q;
    fault_d    = fault_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d    = S_PLAY;
          timer_load = 1'b1;
        end
      end
      S_PLAY: begin
        if (!pause) begin
          if (timer_zero) state_d = S_STEP;
          else            timer_en = 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_CHECK;
        to_d    = '0;
      end
      S_CHECK: begin
        if (check_done) begin
          if (collision) begin
            state_d = S_OVER;
          end else if (score >= WIN_S) begin
            state_d = S_WIN;
          end else begin
            state_d    = S_PLAY;
            timer_load = 1'b1;
          end
        end else if (to_q == TO_LAST) begin
          state_d = S_OVER;
          fault_d = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_OVER, S_WIN: begin
        if (start_rise) state_d = S_RESTART;
      end
      S_RESTART: begin
        state_d = S_IDLE;
        fault_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    step_d      = (state_d == S_STEP);
    check_req_d = (state_d == S_CHECK);
    game_rst_d  = (state_d == S_RESTART);
    playing_d   = (state_d == S_PLAY) || (state_d == S_STEP) || (state_d == S_CHECK);
    game_over_d = (state_d == S_OVER);
    victory_d   = (state_d == S_WIN);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      to_q        <= '0;
      step_q      <= 1'b0;
      check_req_q <= 1'b0;
      game_rst_q  <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      victory_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      to_q        <= to_d;
      step_q      <= step_d;
      check_req_q <= check_req_d;
      game_rst_q  <= game_rst_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
      victory_q   <= victory_d;
      fault_q     <= fault_d;
    end
  end

  assign step      = step_q;
  assign check_req = check_req_q;
  assign game_rst  = game_rst_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;
  assign victory   = victory_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller with a score-to-period reference model.
`default_nettype none

module tb_game_controller;
  import snake_pkg::*;

  localparam int BP = 20;
  localparam int SU = 2;
  localparam int MP = 8;
  localparam int TO = 10;
  localparam int WS = 15;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] score = 4'd0;
  logic       check_done = 1'b0;
  logic       collision = 1'b0;
  logic       step, check_req, game_rst, playing, game_over, victory, fault;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  game_controller #(
    .BASE_PERIOD  (BP),
    .SPEEDUP      (SU),
    .MIN_PERIOD   (MP),
    .WIN_SCORE    (WS),
    .CHECK_TIMEOUT(TO)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .score      (score),
    .check_done (check_done),
    .collision  (collision),
    .step       (step),
    .check_req  (check_req),
    .game_rst   (game_rst),
    .playing    (playing),
    .game_over  (game_over),
    .victory    (victory),
    .fault      (fault),
    .state      (state)
  );

  always #5 pclk = ~pclk;

  // Reference: period shrinks linearly with score, never below the floor.
  function automatic int period_of(input int s);
    int p;
    p = BP - SU * s;
    return (p < MP) ? MP : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // From IDLE: produce a start edge; returns in the PLAY-entry cycle.
  task automatic begin_game(input int sc);
    score = 4'(sc);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("enter_play", state, ST_PLAY);
  endtask

  // From the PLAY-entry cycle: run until step, expecting period + pause cycles.
  task automatic play_segment(input int per, input int pause_at, input int pause_len);
    int c;
    c = 0;
    chk("play_state", state, ST_PLAY);
    chk("playing_hi", playing, 1);
    while (step !== 1'b1 && c < 400) begin
      pause      = (c >= pause_at) && (c < pause_at + pause_len);
      start      = 1'($urandom_range(0, 1));
      check_done = ($urandom_range(0, 7) == 0);
      collision  = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    pause = 1'b0; start = 1'b0; check_done = 1'b0; collision = 1'b0;
    chk("step_latency", c, per + pause_len);
  endtask

  // From the STEP cycle: checker answers lat cycles after check_req rises.
  task automatic check_phase(input int lat, input logic coll, input int new_score,
                             input logic pause_hi);
    logic [2:0] exp_st;
    exp_st = coll ? ST_OVER : ((new_score >= WS) ? ST_WIN : ST_PLAY);
    score = 4'(new_score);
    pause = pause_hi;
    tick();
    chk("step_one_cycle", step, 0);
    chk("check_state", state, ST_CHECK);
    for (int i = 0; i < lat; i++) begin
      chk("check_req_hi", check_req, 1);
      tick();
    end
    check_done = 1'b1;
    collision  = coll;
    tick();
    check_done = 1'b0; collision = 1'b0; pause = 1'b0;
    chk("exit_state", state, exp_st);
    chk("req_drop", check_req, 0);
    chk("playing_out", playing, exp_st == ST_PLAY);
    chk("game_over_out", game_over, exp_st == ST_OVER);
    chk("victory_out", victory, exp_st == ST_WIN);
  endtask

  // From OVER/WIN: start edge, one-cycle game_rst, then IDLE.
  task automatic restart(input logic [2:0] held_st);
    start = 1'b0;
    tick();
    chk("end_hold", state, held_st);
    start = 1'b1;
    tick();
    chk("rst_pulse", game_rst, 1);
    chk("restart_state", state, ST_RESTART);
    tick();
    chk("rst_drop", game_rst, 0);
    chk("idle_after", state, ST_IDLE);
    chk("fault_clr", fault, 0);
    tick();
    start = 1'b0;
    chk("no_retrigger", state, ST_IDLE);
  endtask

  initial begin
    int sc, lat, per, pl, pa, steps;
    logic ph;

    // Asynchronous reset with no clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outs", {step, check_req, game_rst, playing, game_over, victory, fault, state}, 0);
    repeat (2) @(posedge pclk);
    @(negedge pclk) rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_hold", state, ST_IDLE);

    // Score 0 cadence: 20 from entry, then 23 step to step
    begin_game(0);
    play_segment(period_of(0), 0, 0);
    check_phase(1, 1'b0, 0, 1'b0);
    play_segment(period_of(0), 0, 0);
    check_phase(1, 1'b0, 3, 1'b0);
    play_segment(period_of(3), 0, 0);
    check_phase(1, 1'b0, 9, 1'b0);
    play_segment(period_of(9), 0, 0);

    // Pause during CHECK ignored; 7-cycle pause in PLAY delays by 7
    check_phase(1, 1'b0, 0, 1'b1);
    play_segment(period_of(0), 5, 7);

    // Randomized score, checker latency and pause windows
    for (int k = 0; k < 8; k++) begin
      sc  = $urandom_range(0, 14);
      lat = $urandom_range(1, 4);
      per = period_of(sc);
      pl  = $urandom_range(0, 5);
      pa  = $urandom_range(0, per - 1);
      ph  = 1'($urandom_range(0, 1));
      check_phase(lat, 1'b0, sc, ph);
      play_segment(per, pa, pl);
    end

    // Collision at the win score: collision wins
    check_phase(2, 1'b1, 15, 1'b0);
    chk("over_fault_lo", fault, 0);
    restart(ST_OVER);

    // Win with no collision
    begin_game(0);
    play_segment(period_of(0), 0, 0);
    check_phase(1, 1'b0, 15, 1'b0);
    restart(ST_WIN);

    // Checker never answers: timeout after 10 CHECK cycles
    begin_game(0);
    play_segment(period_of(0), 0, 0);
    for (int i = 0; i < TO; i++) begin
      tick();
      chk("timeout_wait", state, ST_CHECK);
    end
    tick();
    chk("timeout_state", state, ST_OVER);
    chk("timeout_fault", fault, 1);
    chk("timeout_over", game_over, 1);
    restart(ST_OVER);

    // Reset during CHECK
    begin_game(0);
    play_segment(period_of(0), 0, 0);
    tick();
    chk("pre_rst_req", check_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {step, check_req, game_rst, playing, game_over, victory, fault, state}, 0);
    steps = 0;
    repeat (3) begin
      tick();
      if (step === 1'b1) steps++;
    end
    @(negedge pclk) rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (step === 1'b1) steps++;
    end
    chk("no_step_after_rst", steps, 0);
    chk("idle_after_rst", state, ST_IDLE);
    begin_game(5);
    play_segment(period_of(5), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
